// File: rtl/ics_refill_ctrl.sv
// rtl/ics_refill_ctrl.sv - instruction-cache line refill and full-cache flush sequencer
//
// Purpose: on a lookup miss, fetch the aligned line one word per beat and write each
// word into the data array, then commit the tag with valid=1. On a flush request,
// invalidate every set one per cycle. o_miss_state holds the front end while busy.
//
// Ports:
//   clk, srst                 clock, synchronous active-high reset
//   i_halt                    global stall, freezes all state and blocks all strobes
//   i_miss, i_miss_addr       lookup miss and its word address
//   i_flush                   request to invalidate all lines
//   o_miss_state              refill/flush in progress
//   o_mem_req_*, i_mem_req_ready   memory read request channel (valid/ready)
//   i_mem_rsp_valid/_data     in-order read data
//   o_data_wr_*               data-array write port
//   o_tag_wr_*                tag-array write port
module ics_refill_ctrl #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int LINE_WORDS  = 4,
  parameter int INDEX_WIDTH = 4,
  localparam int OFFSET_WIDTH = $clog2(LINE_WORDS),
  localparam int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH
) (
  input  logic                    clk,
  input  logic                    srst,
  input  logic                    i_halt,
  input  logic                    i_miss,
  input  logic [ADDR_WIDTH-1:0]   i_miss_addr,
  input  logic                    i_flush,
  output logic                    o_miss_state,
  output logic                    o_mem_req_valid,
  output logic [ADDR_WIDTH-1:0]   o_mem_req_addr,
  input  logic                    i_mem_req_ready,
  input  logic                    i_mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   i_mem_rsp_data,
  output logic                    o_data_wr_en,
  output logic [INDEX_WIDTH-1:0]  o_data_wr_index,
  output logic [OFFSET_WIDTH-1:0] o_data_wr_offset,
  output logic [DATA_WIDTH-1:0]   o_data_wr_data,
  output logic                    o_tag_wr_en,
  output logic [INDEX_WIDTH-1:0]  o_tag_wr_index,
  output logic [TAG_WIDTH-1:0]    o_tag_wr_tag,
  output logic                    o_tag_wr_valid
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FILL   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;
  localparam logic [1:0] S_FLUSH  = 2'd3;

  // One extra counter bit so "all LINE_WORDS requests issued" is representable.
  localparam int CNT_WIDTH = OFFSET_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0]   CNT_LINE = CNT_WIDTH'(LINE_WORDS);
  localparam logic [CNT_WIDTH-1:0]   CNT_LAST = CNT_WIDTH'(LINE_WORDS - 1);
  localparam logic [CNT_WIDTH-1:0]   CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [INDEX_WIDTH-1:0] IDX_LAST = '1;
  localparam logic [INDEX_WIDTH-1:0] IDX_ONE  = INDEX_WIDTH'(1);

  logic [1:0]             state;
  logic [CNT_WIDTH-1:0]   req_cnt;
  logic [CNT_WIDTH-1:0]   rsp_cnt;
  logic [INDEX_WIDTH-1:0] flush_idx;
  logic [INDEX_WIDTH-1:0] line_index;
  logic [TAG_WIDTH-1:0]   line_tag;
  logic                   pend_flush;

  // The word offset of the missing address does not matter: the line is fetched from offset 0.
  logic [OFFSET_WIDTH-1:0] unused_miss_offset;
  assign unused_miss_offset = i_miss_addr[OFFSET_WIDTH-1:0];

  // Strobes are suppressed while in reset or halted so nothing leaks out of a frozen cycle.
  logic active;
  logic req_valid;
  logic req_fire;
  logic rsp_fire;
  logic commit_wr;
  logic flush_wr;

  assign active    = ~srst & ~i_halt;
  assign req_valid = active & (state == S_FILL) & (req_cnt < CNT_LINE);
  assign req_fire  = req_valid & i_mem_req_ready;
  assign rsp_fire  = active & (state == S_FILL) & i_mem_rsp_valid;
  assign commit_wr = active & (state == S_COMMIT);
  assign flush_wr  = active & (state == S_FLUSH);

  assign o_miss_state    = ~srst & (state != S_IDLE);

  assign o_mem_req_valid = req_valid;
  assign o_mem_req_addr  = req_valid ? {line_tag, line_index, req_cnt[OFFSET_WIDTH-1:0]} : '0;

  assign o_data_wr_en     = rsp_fire;
  assign o_data_wr_index  = rsp_fire ? line_index : '0;
  assign o_data_wr_offset = rsp_fire ? rsp_cnt[OFFSET_WIDTH-1:0] : '0;
  assign o_data_wr_data   = rsp_fire ? i_mem_rsp_data : '0;

  assign o_tag_wr_en    = commit_wr | flush_wr;
  assign o_tag_wr_index = commit_wr ? line_index : (flush_wr ? flush_idx : '0);
  assign o_tag_wr_tag   = commit_wr ? line_tag : '0;
  assign o_tag_wr_valid = commit_wr;

  always_ff @(posedge clk) begin
    if (srst) begin
      state      <= S_IDLE;
      req_cnt    <= '0;
      rsp_cnt    <= '0;
      flush_idx  <= '0;
      line_index <= '0;
      line_tag   <= '0;
      pend_flush <= 1'b0;
    end else if (!i_halt) begin
      case (state)
        S_IDLE: begin
          // Flush wins; a simultaneous miss is replayed by the front end afterwards.
          if (i_flush) begin
            state <= S_FLUSH;
          end else if (i_miss) begin
            line_tag   <= i_miss_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
            line_index <= i_miss_addr[OFFSET_WIDTH +: INDEX_WIDTH];
            req_cnt    <= '0;
            rsp_cnt    <= '0;
            state      <= S_FILL;
          end
        end
        S_FILL: begin
          if (req_fire) begin
            req_cnt <= req_cnt + CNT_ONE;
          end
          if (rsp_fire) begin
            rsp_cnt <= rsp_cnt + CNT_ONE;
            if (rsp_cnt == CNT_LAST) begin
              state <= S_COMMIT;
            end
          end
          if (i_flush) begin
            pend_flush <= 1'b1;
          end
        end
        S_COMMIT: begin
          // A flush arriving in the commit cycle itself still chains straight into FLUSH.
          state <= (pend_flush | i_flush) ? S_FLUSH : S_IDLE;
        end
        S_FLUSH: begin
          flush_idx <= flush_idx + IDX_ONE;
          if (flush_idx == IDX_LAST) begin
            state      <= S_IDLE;
            pend_flush <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ics_refill_ctrl.sv
// tb/tb_ics_refill_ctrl.sv - randomized self-checking bench for ics_refill_ctrl
module tb_ics_refill_ctrl;
  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int LW    = 4;
  localparam int IW    = 4;
  localparam int OW    = 2;
  localparam int TW    = AW - IW - OW;
  localparam int NSETS = 1 << IW;
  localparam int K_MISS  = 0;
  localparam int K_FLUSH = 1;
  localparam int K_BOTH  = 2;

  logic clk = 1'b0;
  logic srst, i_halt, i_miss, i_flush, i_mem_req_ready, i_mem_rsp_valid;
  logic [AW-1:0] i_miss_addr;
  logic [DW-1:0] i_mem_rsp_data;
  logic o_miss_state, o_mem_req_valid, o_data_wr_en, o_tag_wr_en, o_tag_wr_valid;
  logic [AW-1:0] o_mem_req_addr;
  logic [IW-1:0] o_data_wr_index, o_tag_wr_index;
  logic [OW-1:0] o_data_wr_offset;
  logic [DW-1:0] o_data_wr_data;
  logic [TW-1:0] o_tag_wr_tag;

  always #5 clk = ~clk;

  ics_refill_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW), .INDEX_WIDTH(IW)) dut (
    .clk(clk), .srst(srst), .i_halt(i_halt), .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .i_flush(i_flush), .o_miss_state(o_miss_state), .o_mem_req_valid(o_mem_req_valid),
    .o_mem_req_addr(o_mem_req_addr), .i_mem_req_ready(i_mem_req_ready),
    .i_mem_rsp_valid(i_mem_rsp_valid), .i_mem_rsp_data(i_mem_rsp_data),
    .o_data_wr_en(o_data_wr_en), .o_data_wr_index(o_data_wr_index),
    .o_data_wr_offset(o_data_wr_offset), .o_data_wr_data(o_data_wr_data),
    .o_tag_wr_en(o_tag_wr_en), .o_tag_wr_index(o_tag_wr_index),
    .o_tag_wr_tag(o_tag_wr_tag), .o_tag_wr_valid(o_tag_wr_valid)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct { logic [AW-1:0] addr; int due; } mreq_t;
  mreq_t mq[$];
  logic [63:0] exp_wr[$];
  logic [63:0] obs_wr[$];
  logic [AW-1:0] exp_req[$];
  int req_cyc[$];

  int cyc = 0;
  int issue_cyc, rise_cyc, fall_cyc, last_tag_cyc, n_rise, n_dwr, n_rsp, n_req_extra;
  int ready_mode, rdy_ph, lat_lo, lat_hi, halt_pct, halt_after, halt_left, flush_at_rsp;
  bit halt_done, inj_miss, inj_flush, spur_en, spurious, flush_appended, ms_prev, hold_pending;
  bit drv_miss, drv_flush, drv_srst;
  logic [AW-1:0] drv_addr, hold_addr;
  logic [15:0] salt;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] memfn(input logic [AW-1:0] a);
    return DW'(a * 16'd40503) ^ salt;
  endfunction

  function automatic logic [63:0] enc_d(input logic [IW-1:0] ix, input logic [OW-1:0] off,
                                        input logic [DW-1:0] d);
    return {4'h1, 12'(ix), 16'(off), 32'(d)};
  endfunction

  function automatic logic [63:0] enc_t(input logic [IW-1:0] ix, input logic [TW-1:0] tg,
                                        input logic v);
    return {4'h2, 12'(ix), 16'(v), 32'(tg)};
  endfunction

  function automatic logic [63:0] all_outs();
    return 64'({o_miss_state, o_mem_req_valid, o_mem_req_addr, o_data_wr_en, o_data_wr_index,
                o_data_wr_offset, o_data_wr_data, o_tag_wr_en, o_tag_wr_index, o_tag_wr_tag,
                o_tag_wr_valid});
  endfunction

  task automatic append_flush();
    for (int i = 0; i < NSETS; i++) exp_wr.push_back(enc_t(IW'(i), '0, 1'b0));
    flush_appended = 1'b1;
  endtask

  // One clock cycle: drive inputs after the falling edge, model memory, then sample outputs.
  task automatic cycle();
    bit halt;
    @(negedge clk);
    cyc++;
    srst = drv_srst;
    if (halt_after >= 0 && !halt_done && n_dwr >= halt_after) begin
      halt_left = 5;
      halt_done = 1'b1;
    end
    halt = (halt_left > 0) || (int'($urandom_range(0, 99)) < halt_pct);
    if (halt_left > 0) halt_left--;
    if (drv_miss || drv_flush || drv_srst) halt = 1'b0;
    i_halt      = halt;
    i_miss      = drv_miss || drv_srst;
    i_flush     = drv_flush;
    i_miss_addr = drv_miss ? drv_addr : AW'($urandom);
    drv_miss    = 1'b0;
    drv_flush   = 1'b0;
    if (!halt && !srst && o_miss_state) begin
      if (inj_miss && $urandom_range(0, 5) == 0) i_miss = 1'b1;
      if (inj_flush && $urandom_range(0, 19) == 0) begin
        i_flush = 1'b1;
        if (!flush_appended) append_flush();
      end
    end
    case (ready_mode)
      0:       i_mem_req_ready = 1'b1;
      1:       i_mem_req_ready = (rdy_ph == 0);
      default: i_mem_req_ready = 1'($urandom_range(0, 1));
    endcase
    rdy_ph = (rdy_ph + 1) % 3;
    i_mem_rsp_valid = 1'b0;
    i_mem_rsp_data  = '0;
    if (srst) begin
      mq.delete();
      hold_pending = 1'b0;
    end
    #1;
    if (!srst) begin
      if (o_mem_req_valid && i_mem_req_ready) begin
        if (exp_req.size() > 0) check_eq("req_addr", 64'(o_mem_req_addr), 64'(exp_req.pop_front()));
        else n_req_extra++;
        mq.push_back('{o_mem_req_addr, cyc + int'($urandom_range(lat_lo, lat_hi))});
        req_cyc.push_back(cyc);
      end
      if (hold_pending && !halt)
        check_eq("req_hold", 64'({o_mem_req_valid, o_mem_req_addr}), 64'({1'b1, hold_addr}));
      if (!halt) begin
        hold_pending = o_mem_req_valid && !i_mem_req_ready;
        hold_addr    = o_mem_req_addr;
      end
      if (!halt && mq.size() > 0 && mq[0].due <= cyc) begin
        i_mem_rsp_valid = 1'b1;
        i_mem_rsp_data  = memfn(mq[0].addr);
        void'(mq.pop_front());
        n_rsp++;
        if (flush_at_rsp == n_rsp && !flush_appended) begin
          i_flush = 1'b1;
          append_flush();
        end
      end else if (!halt && spurious && mq.size() == 0 && $urandom_range(0, 3) == 0) begin
        i_mem_rsp_valid = 1'b1;
        i_mem_rsp_data  = DW'($urandom);
      end
    end
    #1;
    if (o_data_wr_en) begin
      obs_wr.push_back(enc_d(o_data_wr_index, o_data_wr_offset, o_data_wr_data));
      n_dwr++;
    end
    if (o_tag_wr_en) begin
      obs_wr.push_back(enc_t(o_tag_wr_index, o_tag_wr_tag, o_tag_wr_valid));
      last_tag_cyc = cyc;
    end
    if (halt) check_eq("halt_strobes", 64'({o_mem_req_valid, o_data_wr_en, o_tag_wr_en}), 64'd0);
    if (srst) check_eq("rst_outputs", all_outs(), 64'd0);
    if (o_miss_state && !ms_prev) begin
      n_rise++;
      rise_cyc = cyc;
    end
    if (!o_miss_state && ms_prev) fall_cyc = cyc;
    ms_prev = o_miss_state;
  endtask

  task automatic start_op();
    exp_wr.delete(); obs_wr.delete(); exp_req.delete(); req_cyc.delete();
    n_rise = 0; rise_cyc = -1; fall_cyc = -1; last_tag_cyc = -1;
    n_dwr = 0; n_rsp = 0; n_req_extra = 0;
    halt_done = 1'b0; halt_left = 0; flush_appended = 1'b0; hold_pending = 1'b0;
    ms_prev = o_miss_state;
  endtask

  task automatic run_op(input int kind, input logic [AW-1:0] addr, input string name);
    int base, ix, tg;
    bit ended;
    start_op();
    spurious = (kind != K_MISS) && spur_en;
    if (kind == K_MISS) begin
      base = int'(addr) / LW * LW;
      ix   = (int'(addr) / LW) % NSETS;
      tg   = int'(addr) / (LW * NSETS);
      for (int k = 0; k < LW; k++) begin
        exp_req.push_back(AW'(base + k));
        exp_wr.push_back(enc_d(IW'(ix), OW'(k), memfn(AW'(base + k))));
      end
      exp_wr.push_back(enc_t(IW'(ix), TW'(tg), 1'b1));
    end else begin
      append_flush();
    end
    drv_miss  = (kind != K_FLUSH);
    drv_flush = (kind != K_MISS);
    drv_addr  = addr;
    cycle();
    issue_cyc = cyc;
    ended = 1'b0;
    for (int n = 0; n < 2000 && !ended; n++) begin
      cycle();
      ended = (fall_cyc >= 0);
    end
    for (int n = 0; n < 3; n++) cycle();
    spurious = 1'b0;
    check_eq({name, "_done"}, 64'(ended), 64'd1);
    check_eq({name, "_wr_count"}, 64'(obs_wr.size()), 64'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size(); i++)
      check_eq($sformatf("%s_wr%0d", name, i), (i < obs_wr.size()) ? obs_wr[i] : '1, exp_wr[i]);
    check_eq({name, "_req_extra"}, 64'(n_req_extra), 64'd0);
    check_eq({name, "_req_missing"}, 64'(exp_req.size()), 64'd0);
    check_eq({name, "_ms_rises"}, 64'(n_rise), 64'd1);
    check_eq({name, "_ms_rise_cyc"}, 64'(rise_cyc - issue_cyc), 64'd1);
    check_eq({name, "_ms_fall_cyc"}, 64'(fall_cyc - last_tag_cyc), 64'd1);
    if (!ended) begin
      drv_srst = 1'b1;
      cycle();
      drv_srst = 1'b0;
    end
  endtask

  task automatic reset_mid_fill();
    start_op();
    drv_miss = 1'b1;
    drv_addr = AW'($urandom);
    cycle();
    for (int n = 0; n < 50 && n_dwr < 1; n++) cycle();
    check_eq("t6_fill_started", 64'(n_dwr), 64'd1);
    drv_srst = 1'b1;
    cycle();
    drv_srst = 1'b0;
    cycle();
    check_eq("t6_after_reset", all_outs(), 64'd0);
    cycle();
    check_eq("t6_idle", 64'(o_miss_state), 64'd0);
  endtask

  initial begin
    int pick;
    int kind;
    srst = 1'b1; i_halt = 1'b0; i_miss = 1'b0; i_flush = 1'b0; i_miss_addr = '0;
    i_mem_req_ready = 1'b0; i_mem_rsp_valid = 1'b0; i_mem_rsp_data = '0;
    salt = 16'($urandom);
    ready_mode = 0; rdy_ph = 0; lat_lo = 1; lat_hi = 1; halt_pct = 0; halt_after = -1;
    halt_left = 0; flush_at_rsp = 0; halt_done = 1'b0; inj_miss = 1'b0; inj_flush = 1'b0;
    spur_en = 1'b0; spurious = 1'b0; flush_appended = 1'b0; ms_prev = 1'b0; hold_pending = 1'b0;
    drv_miss = 1'b0; drv_flush = 1'b0; drv_addr = '0; hold_addr = '0;

    drv_srst = 1'b1;
    repeat (2) cycle();
    drv_srst = 1'b0;
    cycle();
    check_eq("reset_state", all_outs(), 64'd0);

    // Basic miss with zero-wait memory and one-cycle response latency.
    run_op(K_MISS, 16'h1236, "t1");
    check_eq("t1_req_count", 64'(req_cyc.size()), 64'd4);
    for (int k = 0; k < 4; k++)
      if (k < req_cyc.size()) check_eq($sformatf("t1_req_cyc%0d", k), 64'(req_cyc[k] - issue_cyc), 64'(k + 1));
    check_eq("t1_commit_cyc", 64'(last_tag_cyc - issue_cyc), 64'd6);
    check_eq("t1_tag_write", (obs_wr.size() > 4) ? obs_wr[4] : '1, enc_t(4'hD, 10'h048, 1'b1));
    check_eq("t1_first_data", (obs_wr.size() > 0) ? obs_wr[0] : '1, enc_d(4'hD, 2'd0, memfn(16'h1234)));

    // Backpressure with ready pattern 1,0,0.
    ready_mode = 1;
    run_op(K_MISS, AW'($urandom), "t2");
    check_eq("t2_req_count", 64'(req_cyc.size()), 64'd4);

    // Flush and miss in the same IDLE cycle.
    ready_mode = 0;
    run_op(K_BOTH, AW'($urandom), "t3");
    check_eq("t3_last_flush_cyc", 64'(last_tag_cyc - issue_cyc), 64'd16);
    check_eq("t3_no_requests", 64'(req_cyc.size()), 64'd0);

    // Flush pulsed alongside the second response of a refill.
    flush_at_rsp = 2;
    run_op(K_MISS, AW'($urandom), "t4");
    flush_at_rsp = 0;
    check_eq("t4_total_writes", 64'(obs_wr.size()), 64'(LW + 1 + NSETS));

    // Five-cycle halt after two data writes.
    halt_after = 2;
    run_op(K_MISS, AW'($urandom), "t5");
    halt_after = -1;
    check_eq("t5_halt_applied", 64'(halt_done), 64'd1);

    // Reset in the middle of a fill, then a fresh miss to 0x0040.
    reset_mid_fill();
    run_op(K_MISS, 16'h0040, "t6");
    check_eq("t6_tag_write", (obs_wr.size() > 4) ? obs_wr[4] : '1, enc_t(4'h0, 10'h001, 1'b1));

    // Randomized operations with random ready, latency, halts and stray requests.
    ready_mode = 2; lat_lo = 0; lat_hi = 3; halt_pct = 10;
    inj_miss = 1'b1; inj_flush = 1'b1; spur_en = 1'b1;
    for (int r = 0; r < 40; r++) begin
      pick = int'($urandom_range(0, 5));
      kind = (pick < 4) ? K_MISS : ((pick == 4) ? K_FLUSH : K_BOTH);
      run_op(kind, AW'($urandom), $sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ics_refill_ctrl.md
Name: ics_refill_ctrl

Overview:
Instruction-cache refill and flush controller. Sits beside the tag-compare stage. On a lookup miss it fetches the full line from backing memory one word per beat and writes each word into the data array. It then commits the tag with valid=1. Its o_miss_state output is the miss-state input of the front-end restart logic: that logic holds fetch while o_miss_state is high and replays the stalled address when it falls. It also sequences a full-cache invalidate on request.

Parameters:
ADDR_WIDTH, 16, word-address width
DATA_WIDTH, 16, instruction word width
LINE_WORDS, 4, words per line (power of two, >=2); OFFSET_WIDTH = clog2(LINE_WORDS)
INDEX_WIDTH, 4, set index width; TAG_WIDTH = ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH

Ports:
clk  in  1  clock
srst  in  1  synchronous active-high reset
i_halt  in  1  global stall; freezes all state
i_miss  in  1  lookup missed this cycle
i_miss_addr  in  ADDR_WIDTH  missing word address
i_flush  in  1  request invalidate of all lines
o_miss_state  out  1  refill/flush in progress (registered)
o_mem_req_valid  out  1  memory read request valid
o_mem_req_addr  out  ADDR_WIDTH  request word address
i_mem_req_ready  in  1  memory accepts request
i_mem_rsp_valid  in  1  read data valid (in order)
i_mem_rsp_data  in  DATA_WIDTH  read data
o_data_wr_en  out  1  data-array write strobe
o_data_wr_index  out  INDEX_WIDTH  data-array set
o_data_wr_offset  out  OFFSET_WIDTH  word within line
o_data_wr_data  out  DATA_WIDTH  word to write
o_tag_wr_en  out  1  tag-array write strobe
o_tag_wr_index  out  INDEX_WIDTH  tag-array set
o_tag_wr_tag  out  TAG_WIDTH  tag value
o_tag_wr_valid  out  1  valid bit written with tag

Behaviour:
- Reset: srst high at a clk edge -> state IDLE, req/rsp counters 0, flush index 0, pending-flush 0, latched address 0.
- All outputs are 0 during and immediately after reset.
- Reset mid-refill or mid-flush aborts the operation. Memory is reset in the same cycle; stale responses never arrive.
- States: IDLE, FILL, COMMIT, FLUSH.
- IDLE:
  - i_flush=1 -> FLUSH. Flush wins over a simultaneous i_miss; that miss is dropped and the front end replays it after the flush.
  - Else i_miss=1 -> latch tag and index of i_miss_addr, clear both counters, go to FILL.
- FILL, requests:
  - o_mem_req_valid=1 while req_cnt<LINE_WORDS.
  - o_mem_req_addr = {tag, index, req_cnt}; the line is fetched aligned, offset 0 first.
  - req_cnt increments on valid&ready.
  - Valid must stay asserted and the address stable until ready.
- FILL, responses:
  - Each i_mem_rsp_valid drives o_data_wr_en=1 in the same cycle (combinational), with o_data_wr_offset=rsp_cnt, the latched index, and o_data_wr_data=i_mem_rsp_data.
  - rsp_cnt increments on each response.
  - Requests and responses overlap freely. A response arriving in the same cycle as its own request acceptance is legal.
- FILL exit: after the response with rsp_cnt=LINE_WORDS-1 is accepted, go to COMMIT.
- COMMIT: exactly one cycle. o_tag_wr_en=1, latched index and tag, o_tag_wr_valid=1. Next state is FLUSH if pending-flush=1, else IDLE.
- FLUSH:
  - One set per cycle: o_tag_wr_en=1, o_tag_wr_index=flush_idx, o_tag_wr_tag=0, o_tag_wr_valid=0.
  - After index 2^INDEX_WIDTH-1 is written, return to IDLE with flush_idx wrapped to 0 and pending-flush cleared.
- i_flush outside IDLE:
  - During FILL or COMMIT it sets pending-flush. The flush runs after COMMIT, and o_miss_state stays high continuously.
  - During FLUSH it is ignored.
- i_miss outside IDLE is ignored.
- o_miss_state is registered: 1 in every cycle the registered state is FILL, COMMIT or FLUSH; 0 in IDLE.
  - It first rises the cycle after i_miss is sampled.
  - It falls the cycle after COMMIT or after the last flush write.
- i_halt=1 (checked after srst):
  - State, counters and latches hold.
  - o_mem_req_valid, o_data_wr_en and o_tag_wr_en are forced 0; no handshake completes.
  - o_miss_state holds its value.
  - Memory shares i_halt and does not assert i_mem_rsp_valid while halted. Any response presented during halt is ignored.
- Counters are OFFSET_WIDTH+1 bits wide so LINE_WORDS is representable; address offset = low OFFSET_WIDTH bits.
- i_mem_rsp_valid outside FILL is ignored; no write is issued.

Test Plan:
1. Basic miss, zero-wait memory: defaults, ready=1, rsp latency 1, i_miss with addr 0x1236 -> requests 0x1234..0x1237 on 4 consecutive cycles; data writes at index 0xD, offsets 0..3; tag write index 0xD, tag 0x048, valid=1; o_miss_state high exactly from cycle 1 through the COMMIT cycle.
2. Backpressure: ready toggles 1,0,0,1,... -> o_mem_req_addr held stable while ready=0; exactly 4 accepted requests; no duplicate or skipped offsets.
3. Flush in IDLE: i_flush and i_miss both high in the same cycle -> 16 tag writes, index 0..15, valid=0, on 16 consecutive cycles; no memory requests; o_miss_state high 16 cycles, then low.
4. Flush during refill: i_flush pulsed at the 2nd response of a miss -> refill completes and commits, then 16 flush writes follow; o_miss_state has no gap.
5. Halt mid-fill: i_halt=1 for 5 cycles after 2 responses -> no strobes, counters hold; after release the remaining offsets 2,3 are written and the line commits.
6. Reset mid-fill: srst for 1 cycle after 1 response -> next cycle all outputs 0 and state IDLE; a fresh miss to 0x0040 then refills index 0, tag 0x001.
